// File: rtl/pkt_rr_arb.sv
// Packet-level round-robin arbiter merging two show-ahead packing FIFOs into one
// packet stream; grant is held sop..eop and malformed leading words are flushed.
module pkt_rr_arb #(
   parameter int DW = 16,
   parameter int MW = 1,
   parameter int FW = DW + MW + 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          empty0,
   input  logic [FW-1:0] q0,
   output logic          rdreq0,
   input  logic          empty1,
   input  logic [FW-1:0] q1,
   output logic          rdreq1,
   input  logic          b_rdy,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic          dout_sop,
   output logic          dout_eop,
   output logic [MW-1:0] dout_mty,
   output logic          dout_ch,
   output logic          err_drop
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          first_q, first_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          dout_vld_q, dout_vld_d;
   logic          dout_sop_q, dout_sop_d;
   logic          dout_eop_q, dout_eop_d;
   logic [MW-1:0] dout_mty_q, dout_mty_d;
   logic          dout_ch_q, dout_ch_d;
   logic          err_drop_q, err_drop_d;

   logic          pop0, pop1;
   logic          req0, req1;
   logic          sel_ch;
   logic          sel_empty;
   logic [FW-1:0] sel_w;
   logic          w_sop, w_eop;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      first_d      = first_q;
      dout_d       = dout_q;
      dout_vld_d   = 1'b0;
      dout_sop_d   = 1'b0;
      dout_eop_d   = 1'b0;
      dout_mty_d   = '0;
      dout_ch_d    = dout_ch_q;
      err_drop_d   = 1'b0;
      pop0         = 1'b0;
      pop1         = 1'b0;
      req0         = !empty0 && q0[FW-1];
      req1         = !empty1 && q1[FW-1];
      sel_ch       = (state_q == GNT1);
      sel_w        = sel_ch ? q1 : q0;
      sel_empty    = sel_ch ? empty1 : empty0;
      w_sop        = sel_w[FW-1];
      w_eop        = sel_w[FW-2];

      case (state_q)
         IDLE: begin
            // Flush a headless word (ch0 first); the other channel may still win the grant.
            if (!empty0 && !q0[FW-1]) begin
               pop0       = b_rdy;
               err_drop_d = b_rdy;
            end else if (!empty1 && !q1[FW-1]) begin
               pop1       = b_rdy;
               err_drop_d = b_rdy;
            end
            if (req0 && (!req1 || last_grant_q)) begin
               state_d = GNT0;
               first_d = 1'b1;
            end else if (req1) begin
               state_d = GNT1;
               first_d = 1'b1;
            end
         end
         GNT0, GNT1: begin
            if (!sel_empty && b_rdy) begin
               pop0       = !sel_ch;
               pop1       = sel_ch;
               dout_d     = sel_w[DW-1:0];
               dout_vld_d = 1'b1;
               dout_sop_d = w_sop && first_q;
               dout_eop_d = w_eop;
               dout_mty_d = w_eop ? sel_w[DW+MW-1:DW] : '0;
               dout_ch_d  = sel_ch;
               err_drop_d = w_sop && !first_q;
               first_d    = 1'b0;
               if (w_eop) begin
                  state_d      = IDLE;
                  last_grant_d = sel_ch;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         first_q      <= 1'b0;
         dout_q       <= '0;
         dout_vld_q   <= 1'b0;
         dout_sop_q   <= 1'b0;
         dout_eop_q   <= 1'b0;
         dout_mty_q   <= '0;
         dout_ch_q    <= 1'b0;
         err_drop_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
         dout_q       <= dout_d;
         dout_vld_q   <= dout_vld_d;
         dout_sop_q   <= dout_sop_d;
         dout_eop_q   <= dout_eop_d;
         dout_mty_q   <= dout_mty_d;
         dout_ch_q    <= dout_ch_d;
         err_drop_q   <= err_drop_d;
      end
   end

   // Pops are masked while reset is held so a FIFO is never drained during reset.
   assign rdreq0   = pop0 && rst_n;
   assign rdreq1   = pop1 && rst_n;
   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign dout_sop = dout_sop_q;
   assign dout_eop = dout_eop_q;
   assign dout_mty = dout_mty_q;
   assign dout_ch  = dout_ch_q;
   assign err_drop = err_drop_q;

endmodule
